dcache_controller: RTL

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a multi-cycle off-chip data memory. It replaces the single-cycle data memory downstream of EX/MEM. A hit returns read data combinationally with no stall. A miss holds `p1_stall_o` high while a state machine writes back any dirty victim line, fetches the new 256-bit line, and then replays the access as a hit.

---
 rtl/dcache_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// a multi-cycle line-wide off-chip memory. Hits are stall-free; misses run an FSM.
module dcache_controller #(
  parameter int LINES = 32,
  parameter int TAGW  = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic         mem_req_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int IDXW = $clog2(LINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_READMISS,
    S_READMISSOK
  } state_e;

  state_e             state_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAGW-1:0]    tag_q  [LINES];
  logic [255:0]       data_q [LINES];

  logic               mem_req_q;
  logic               mem_write_q;
  logic [31:0]        mem_addr_q;
  logic [255:0]       mem_data_q;

  logic [IDXW-1:0]    idx;
  logic [2:0]         word;
  logic [TAGW-1:0]    tag;
  logic               req;
  logic               hit;
  logic               fill;
  logic               store_hit;
  logic [1:0]         unused_byte_offset;

  assign idx                = p1_addr_i[5 +: IDXW];
  assign word               = p1_addr_i[4:2];
  assign tag                = p1_addr_i[31 -: TAGW];
  assign unused_byte_offset = p1_addr_i[1:0];

  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign fill      = (state_q == S_READMISS) && mem_ack_i;
  assign store_hit = (state_q == S_IDLE) && p1_MemWrite_i && hit;

  assign p1_data_o  = data_q[idx][{word, 5'b00000} +: 32];
  assign p1_stall_o = (req && !hit && (state_q == S_IDLE)) || (state_q != S_IDLE);

  assign mem_req_o   = mem_req_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

  // Control state: FSM, valid/dirty bits and the registered memory-side outputs.
  // The memory request is set up on the transition into WRITEBACK/READMISS so it
  // is already stable in the first cycle of those states.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && !hit) begin
            state_q <= S_MISS;
          end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        S_MISS: begin
          mem_req_q <= 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_q     <= S_WRITEBACK;
            mem_write_q <= 1'b1;
            mem_addr_q  <= {tag_q[idx], idx, 5'b00000};
            mem_data_q  <= data_q[idx];
          end else begin
            state_q     <= S_READMISS;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {p1_addr_i[31:5], 5'b00000};
          end
        end
        S_WRITEBACK: begin
          // Chain straight into the fetch without dropping the request.
          if (mem_ack_i) begin
            state_q     <= S_READMISS;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {p1_addr_i[31:5], 5'b00000};
          end
        end
        S_READMISS: begin
          if (mem_ack_i) begin
            state_q      <= S_READMISSOK;
            mem_req_q    <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        S_READMISSOK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone guards their contents.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx]  <= tag;
    end else if (store_hit) begin
      data_q[idx][{word, 5'b00000} +: 32] <= p1_data_i;
    end
  end

endmodule
